// File: rtl/stim_sequencer.sv
// Vector-memory stimulus sequencer: plays stored entries one per cycle.
// Optional continuous replay is enabled by defining STIM_SEQUENCER_LOOP_EN.
module stim_sequencer #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH:0]   wr_data,
  input  logic [AW:0]      length,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  output logic [WIDTH-1:0] stim_out,
  output logic             obs,
  output logic [AW:0]      pc,
  output logic             busy,
  output logic             done,
  output logic             wr_err,
  output logic [7:0]       loop_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AW:0] DMAX = (AW+1)'(DEPTH);

  state_t         state;
  logic [WIDTH:0] mem [DEPTH];
  logic [AW:0]    len_q;
  logic [AW:0]    len_clamp;
  logic           wr_ok;
  logic [WIDTH:0] head;
  logic [WIDTH:0] nxt;

`ifdef STIM_SEQUENCER_LOOP_EN
  logic           loop_q;
`else
  logic           unused_loop;
  assign unused_loop = loop_en;
`endif

  assign len_clamp = (length > DMAX) ? DMAX : length;
  assign wr_ok     = wr_en && (state != RUN)
                     && ({1'b0, wr_addr} < DMAX);
  assign head      = mem[0];
  assign nxt       = mem[pc[AW-1:0]];

  // Vector memory write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (!reset && wr_ok)
      mem[wr_addr] <= wr_data;
  end

  // Playback FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      stim_out <= '0;
      obs      <= 1'b0;
      pc       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_err   <= 1'b0;
      loop_cnt <= '0;
      len_q    <= '0;
`ifdef STIM_SEQUENCER_LOOP_EN
      loop_q   <= 1'b0;
`endif
    end else begin
      wr_err <= wr_en && !wr_ok;
      unique case (state)
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            obs   <= 1'b0;
          end else if (pc == len_q) begin
`ifdef STIM_SEQUENCER_LOOP_EN
            if (loop_q) begin
              stim_out <= head[WIDTH-1:0];
              obs      <= head[WIDTH];
              pc       <= (AW+1)'(1);
              if (loop_cnt != 8'hff)
                loop_cnt <= loop_cnt + 8'd1;
            end else
`endif
            begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              obs   <= 1'b0;
            end
          end else begin
            stim_out <= nxt[WIDTH-1:0];
            obs      <= nxt[WIDTH];
            pc       <= pc + (AW+1)'(1);
          end
        end
        default: begin
          if (start) begin
            loop_cnt <= '0;
            len_q    <= len_clamp;
`ifdef STIM_SEQUENCER_LOOP_EN
            loop_q   <= loop_en;
`endif
            if (len_clamp == '0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              obs   <= 1'b0;
              pc    <= '0;
            end else begin
              state    <= RUN;
              busy     <= 1'b1;
              done     <= 1'b0;
              stim_out <= head[WIDTH-1:0];
              obs      <= head[WIDTH];
              pc       <= (AW+1)'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stim_sequencer.sv
// Self-checking bench for stim_sequencer (DEPTH=12 so out-of-range
// addresses are reachable); directed table, corner sequences, random.
module tb_stim_sequencer;

  localparam int W  = 2;
  localparam int D  = 12;
  localparam int AW = 4;
`ifdef STIM_SEQUENCER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, wr_en, start, stop, loop_en;
  logic [AW-1:0] wr_addr;
  logic [W:0]    wr_data;
  logic [AW:0]   length;
  logic [W-1:0]  stim_out;
  logic          obs, busy, done, wr_err;
  logic [AW:0]   pc;
  logic [7:0]    loop_cnt;

  stim_sequencer #(.WIDTH(W), .DEPTH(D), .AW(AW)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .length(length),
    .start(start), .stop(stop), .loop_en(loop_en),
    .stim_out(stim_out), .obs(obs), .pc(pc), .busy(busy),
    .done(done), .wr_err(wr_err), .loop_cnt(loop_cnt)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
  endtask

  // Reference model: mode 0=idle 1=run 2=done; t counts entries
  // issued since start, so the entry index is (t-1) mod L.
  logic [W:0] m_mem [D];
  int m_mode, m_t, m_L, m_stim, m_obs, m_pc, m_werr, m_lcnt;
  bit m_loop;

  task automatic model_edge();
    bit acc;
    int idx;
    logic [W:0] e;
    if (reset) begin
      m_mode = 0; m_stim = 0; m_obs = 0; m_pc = 0;
      m_werr = 0; m_lcnt = 0;
      return;
    end
    acc = wr_en && m_mode != 1 && int'(wr_addr) < D;
    m_werr = (wr_en && !acc) ? 1 : 0;
    if (m_mode == 1) begin
      if (stop) begin
        m_mode = 0; m_obs = 0;
      end else if (!m_loop && m_t == m_L) begin
        m_mode = 2; m_obs = 0;
      end else begin
        m_t++;
        idx = (m_t - 1) % m_L;
        e = m_mem[idx];
        m_stim = int'(e[W-1:0]);
        m_obs = int'(e[W]);
        m_pc = idx + 1;
        m_lcnt = ((m_t - 1) / m_L > 255) ? 255 : (m_t - 1) / m_L;
      end
    end else if (start) begin
      m_L = (int'(length) > D) ? D : int'(length);
      m_lcnt = 0;
      if (m_L == 0) begin
        m_mode = 2; m_obs = 0; m_pc = 0;
      end else begin
        m_t = 1;
        m_loop = LOOP && loop_en;
        e = m_mem[0];
        m_stim = int'(e[W-1:0]);
        m_obs = int'(e[W]);
        m_pc = 1;
        m_mode = 1;
      end
    end
    if (acc) m_mem[wr_addr] = wr_data;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    check("m_stim", int'(stim_out), m_stim);
    check("m_obs", int'(obs), m_obs);
    check("m_pc", int'(pc), m_pc);
    check("m_busy", int'(busy), (m_mode == 1) ? 1 : 0);
    check("m_done", int'(done), (m_mode == 2) ? 1 : 0);
    check("m_wr_err", int'(wr_err), m_werr);
    check("m_loop_cnt", int'(loop_cnt), m_lcnt);
  endtask

  task automatic idle_in();
    reset = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    length = 0; start = 0; stop = 0; loop_en = 0;
  endtask

  typedef struct {
    logic rst, we;
    logic [AW-1:0] wa;
    logic [W:0] wd;
    logic [AW:0] len;
    logic st, sp;
    logic [W-1:0] e_stim;
    logic e_obs;
    logic [AW:0] e_pc;
    logic e_busy, e_done, e_werr;
  } vec_t;

  function automatic vec_t mk(logic rst, logic we, int wa, int wd,
      int len, logic st, logic sp, int es, logic eo, int ep,
      logic eb, logic ed, logic ew);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = AW'(wa); v.wd = (W+1)'(wd);
    v.len = (AW+1)'(len); v.st = st; v.sp = sp;
    v.e_stim = W'(es); v.e_obs = eo; v.e_pc = (AW+1)'(ep);
    v.e_busy = eb; v.e_done = ed; v.e_werr = ew;
    return v;
  endfunction

  vec_t tbl[26];

  initial begin
    int cnt;
    int guard;
    tbl[0]  = mk(1,0,0,0,0,0,0, 0,0,0,0,0,0);
    tbl[1]  = mk(0,1,0,3'b001,0,0,0, 0,0,0,0,0,0);
    tbl[2]  = mk(0,1,1,3'b110,0,0,0, 0,0,0,0,0,0);
    tbl[3]  = mk(0,1,2,3'b011,0,0,0, 0,0,0,0,0,0);
    tbl[4]  = mk(0,1,D,3'b111,0,0,0, 0,0,0,0,0,1);
    tbl[5]  = mk(0,0,0,0,0,0,0, 0,0,0,0,0,0);
    tbl[6]  = mk(0,0,0,0,3,1,0, 1,0,1,1,0,0);
    tbl[7]  = mk(0,0,0,0,0,0,0, 2,1,2,1,0,0);
    tbl[8]  = mk(0,0,0,0,0,0,0, 3,0,3,1,0,0);
    tbl[9]  = mk(0,0,0,0,0,0,0, 3,0,3,0,1,0);
    tbl[10] = mk(0,0,0,0,0,0,0, 3,0,3,0,1,0);
    tbl[11] = mk(0,0,0,0,0,0,1, 3,0,3,0,1,0);
    tbl[12] = mk(0,0,0,0,3,1,0, 1,0,1,1,0,0);
    tbl[13] = mk(0,1,0,3'b111,0,0,0, 2,1,2,1,0,1);
    tbl[14] = mk(0,0,0,0,0,0,0, 3,0,3,1,0,0);
    tbl[15] = mk(0,0,0,0,0,0,0, 3,0,3,0,1,0);
    tbl[16] = mk(0,0,0,0,3,1,0, 1,0,1,1,0,0);
    tbl[17] = mk(0,0,0,0,3,1,1, 1,0,1,0,0,0);
    tbl[18] = mk(0,0,0,0,0,0,0, 1,0,1,0,0,0);
    tbl[19] = mk(0,0,0,0,0,1,0, 1,0,0,0,1,0);
    tbl[20] = mk(0,0,0,0,0,0,0, 1,0,0,0,1,0);
    tbl[21] = mk(0,0,0,0,3,1,0, 1,0,1,1,0,0);
    tbl[22] = mk(1,1,1,3'b000,3,1,0, 0,0,0,0,0,0);
    tbl[23] = mk(0,0,0,0,3,1,0, 1,0,1,1,0,0);
    tbl[24] = mk(0,0,0,0,0,0,0, 2,1,2,1,0,0);
    tbl[25] = mk(1,0,0,0,0,0,0, 0,0,0,0,0,0);

    idle_in();
    reset = 1;
    tick();
    reset = 0;
    for (int i = 0; i < D; i++) begin
      wr_en = 1; wr_addr = AW'(i); wr_data = (W+1)'(i * 3 + 2);
      tick();
    end
    idle_in();

    // Directed table
    for (int i = 0; i < 26; i++) begin
      idle_in();
      reset = tbl[i].rst; wr_en = tbl[i].we;
      wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      length = tbl[i].len; start = tbl[i].st; stop = tbl[i].sp;
      tick();
      check($sformatf("t%0d_stim", i), int'(stim_out), int'(tbl[i].e_stim));
      check($sformatf("t%0d_obs", i), int'(obs), int'(tbl[i].e_obs));
      check($sformatf("t%0d_pc", i), int'(pc), int'(tbl[i].e_pc));
      check($sformatf("t%0d_busy", i), int'(busy), int'(tbl[i].e_busy));
      check($sformatf("t%0d_done", i), int'(done), int'(tbl[i].e_done));
      check($sformatf("t%0d_werr", i), int'(wr_err), int'(tbl[i].e_werr));
      check($sformatf("t%0d_lcnt", i), int'(loop_cnt), 0);
    end
    idle_in();

    // Stop in cycle 2 of a 5-entry run
    start = 1; length = 5; tick();
    start = 0; tick(); tick();
    stop = 1; tick();
    stop = 0;
    check("stop_busy", int'(busy), 0);
    check("stop_pc", int'(pc), 3);
    check("stop_stim", int'(stim_out), int'(m_mem[2][W-1:0]));
    check("stop_obs", int'(obs), 0);

    // Oversized length plays exactly DEPTH entries
    start = 1; length = (AW+1)'(D + 3); tick();
    start = 0;
    cnt = int'(busy);
    guard = 0;
    while (!done && guard < 40) begin
      tick();
      cnt += int'(busy);
      guard++;
    end
    check("clamp_done", int'(done), 1);
    check("clamp_count", cnt, D);
    check("clamp_stim", int'(stim_out), int'(m_mem[D-1][W-1:0]));

    // Zero length: done next cycle without busy
    start = 1; length = 0; tick();
    start = 0;
    check("zero_done", int'(done), 1);
    check("zero_busy", int'(busy), 0);

    // Loop request of length 2
    start = 1; length = 2; loop_en = 1; tick();
    start = 0; loop_en = 0;
    check("loop_a0", int'(stim_out), int'(m_mem[0][W-1:0]));
    tick();
    check("loop_b0", int'(stim_out), int'(m_mem[1][W-1:0]));
    tick();
    if (LOOP) begin
      check("loop_a1", int'(stim_out), int'(m_mem[0][W-1:0]));
      check("loop_busy", int'(busy), 1);
      tick();
      check("loop_b1", int'(stim_out), int'(m_mem[1][W-1:0]));
      tick();
      check("loop_cnt2", int'(loop_cnt), 2);
      stop = 1; tick();
      stop = 0;
      check("loop_stop", int'(busy), 0);
    end else begin
      check("noloop_done", int'(done), 1);
      check("noloop_cnt", int'(loop_cnt), 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 39) == 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = AW'($urandom_range(0, 15));
      wr_data = (W+1)'($urandom);
      length  = (AW+1)'($urandom_range(0, 31));
      start   = ($urandom_range(0, 5) == 0);
      stop    = ($urandom_range(0, 9) == 0);
      loop_en = $urandom_range(0, 1) == 1;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
